// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges memory and ALU result streams onto one register-file
// write port and ROB completion bus, buffering ALU results that lose arbitration.
module writeback_arbiter #(
    parameter int ROBINDEX   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,
    input  logic                ALU_Valid_IN,
    input  logic [ROBINDEX-1:0] ALU_ROBPointer_IN,
    input  logic [5:0]          ALU_Dest_IN,
    input  logic                ALU_RegWrite_IN,
    input  logic [31:0]         ALU_Data_IN,
    input  logic                MEM_Valid_IN,
    input  logic [ROBINDEX-1:0] MEM_ROBPointer_IN,
    input  logic [5:0]          MEM_Dest_IN,
    input  logic                MEM_RegWrite_IN,
    input  logic [31:0]         MEM_Data_IN,
    output logic [31:0]         write_register_data,
    output logic [5:0]          write_register_index,
    output logic                write_register_flag,
    output logic                Complete_Valid_OUT,
    output logic [ROBINDEX-1:0] Complete_ROBPointer_OUT,
    output logic                ALU_Stall_OUT,
    output logic                Overflow_OUT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ROBINDEX-1:0] rob;
        logic [5:0]          dest;
        logic                rw;
        logic [31:0]         data;
    } wb_ent_t;

    wb_ent_t         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    wb_ent_t alu_ent;
    wb_ent_t mem_ent;
    wb_ent_t sel_ent;
    logic    sel_valid;
    logic    empty;
    logic    full;
    logic    sel_mem;
    logic    sel_fifo;
    logic    sel_alu;
    logic    pop;
    logic    push_req;
    logic    push_ok;
    logic    drop;
    logic    wr_en;

    assign alu_ent = '{ALU_ROBPointer_IN, ALU_Dest_IN, ALU_RegWrite_IN, ALU_Data_IN};
    assign mem_ent = '{MEM_ROBPointer_IN, MEM_Dest_IN, MEM_RegWrite_IN, MEM_Data_IN};

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign sel_mem  = MEM_Valid_IN;
    assign sel_fifo = !MEM_Valid_IN && !empty;
    assign sel_alu  = !MEM_Valid_IN && empty && ALU_Valid_IN;
    assign pop      = sel_fifo;
    assign push_req = ALU_Valid_IN && !sel_alu;
    // A pop in the same cycle frees the slot, so a full buffer only drops when MEM wins.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign wr_en    = !RESET && !FREEZE && push_ok;

    assign ALU_Stall_OUT = (count >= CW'(FIFO_DEPTH - 1));

    always_comb begin
        sel_ent   = '0;
        sel_valid = 1'b0;
        unique case (1'b1)
            sel_mem: begin
                sel_ent   = mem_ent;
                sel_valid = 1'b1;
            end
            sel_fifo: begin
                sel_ent   = fifo_q[rd_ptr];
                sel_valid = 1'b1;
            end
            sel_alu: begin
                sel_ent   = alu_ent;
                sel_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fifo_q[wr_ptr] <= alu_ent;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr                  <= '0;
            wr_ptr                  <= '0;
            count                   <= '0;
            Overflow_OUT            <= 1'b0;
            write_register_data     <= '0;
            write_register_index    <= '0;
            write_register_flag     <= 1'b0;
            Complete_Valid_OUT      <= 1'b0;
            Complete_ROBPointer_OUT <= '0;
        end else if (FREEZE) begin
            write_register_flag <= 1'b0;
            Complete_Valid_OUT  <= 1'b0;
        end else begin
            write_register_flag <= sel_valid && sel_ent.rw;
            Complete_Valid_OUT  <= sel_valid;
            if (sel_valid) begin
                write_register_data     <= sel_ent.data;
                write_register_index    <= sel_ent.dest;
                Complete_ROBPointer_OUT <= sel_ent.rob;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                Overflow_OUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios then random traffic,
// all checked against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FREEZE;
    logic        ALU_Valid_IN;
    logic [5:0]  ALU_ROBPointer_IN;
    logic [5:0]  ALU_Dest_IN;
    logic        ALU_RegWrite_IN;
    logic [31:0] ALU_Data_IN;
    logic        MEM_Valid_IN;
    logic [5:0]  MEM_ROBPointer_IN;
    logic [5:0]  MEM_Dest_IN;
    logic        MEM_RegWrite_IN;
    logic [31:0] MEM_Data_IN;
    logic [31:0] write_register_data;
    logic [5:0]  write_register_index;
    logic        write_register_flag;
    logic        Complete_Valid_OUT;
    logic [5:0]  Complete_ROBPointer_OUT;
    logic        ALU_Stall_OUT;
    logic        Overflow_OUT;

    writeback_arbiter #(.ROBINDEX(6), .FIFO_DEPTH(DEPTH)) dut (
        .CLK                     (CLK),
        .RESET                   (RESET),
        .FREEZE                  (FREEZE),
        .ALU_Valid_IN            (ALU_Valid_IN),
        .ALU_ROBPointer_IN       (ALU_ROBPointer_IN),
        .ALU_Dest_IN             (ALU_Dest_IN),
        .ALU_RegWrite_IN         (ALU_RegWrite_IN),
        .ALU_Data_IN             (ALU_Data_IN),
        .MEM_Valid_IN            (MEM_Valid_IN),
        .MEM_ROBPointer_IN       (MEM_ROBPointer_IN),
        .MEM_Dest_IN             (MEM_Dest_IN),
        .MEM_RegWrite_IN         (MEM_RegWrite_IN),
        .MEM_Data_IN             (MEM_Data_IN),
        .write_register_data     (write_register_data),
        .write_register_index    (write_register_index),
        .write_register_flag     (write_register_flag),
        .Complete_Valid_OUT      (Complete_Valid_OUT),
        .Complete_ROBPointer_OUT (Complete_ROBPointer_OUT),
        .ALU_Stall_OUT           (ALU_Stall_OUT),
        .Overflow_OUT            (Overflow_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        rw;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_flag, m_cv, m_ovf;
    logic [31:0] m_data;
    logic [5:0]  m_idx, m_rob;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RESET = 1'b0; FREEZE = 1'b0;
        ALU_Valid_IN = 1'b0; MEM_Valid_IN = 1'b0;
    endtask

    task automatic alu(input int rob, input int dest, input bit rw, input logic [31:0] d);
        ALU_Valid_IN = 1'b1; ALU_ROBPointer_IN = 6'(rob);
        ALU_Dest_IN = 6'(dest); ALU_RegWrite_IN = rw; ALU_Data_IN = d;
    endtask

    task automatic mem(input int rob, input int dest, input bit rw, input logic [31:0] d);
        MEM_Valid_IN = 1'b1; MEM_ROBPointer_IN = 6'(rob);
        MEM_Dest_IN = 6'(dest); MEM_RegWrite_IN = rw; MEM_Data_IN = d;
    endtask

    // Model the edge from the currently driven inputs, clock, then compare every output.
    task automatic step(input string tag);
        ent_t a, m, o;
        bit   sel, taken;
        a = '{ALU_ROBPointer_IN, ALU_Dest_IN, ALU_RegWrite_IN, ALU_Data_IN};
        m = '{MEM_ROBPointer_IN, MEM_Dest_IN, MEM_RegWrite_IN, MEM_Data_IN};
        o = a;
        if (RESET) begin
            q.delete();
            m_ovf = 0; m_flag = 0; m_cv = 0; m_data = 0; m_idx = 0; m_rob = 0;
        end else if (FREEZE) begin
            m_flag = 0; m_cv = 0;
        end else begin
            sel = 1; taken = 0;
            if (MEM_Valid_IN) o = m;
            else if (q.size() > 0) o = q.pop_front();
            else if (ALU_Valid_IN) taken = 1;
            else sel = 0;
            if (ALU_Valid_IN && !taken) begin
                if (q.size() < DEPTH) q.push_back(a);
                else m_ovf = 1;
            end
            m_cv = sel;
            m_flag = sel && o.rw;
            if (sel) begin
                m_data = o.data; m_idx = o.dest; m_rob = o.rob;
            end
        end
        @(posedge CLK);
        #1;
        chk({tag, ".cv"},    32'(Complete_Valid_OUT),      32'(m_cv));
        chk({tag, ".flag"},  32'(write_register_flag),     32'(m_flag));
        chk({tag, ".ovf"},   32'(Overflow_OUT),            32'(m_ovf));
        chk({tag, ".stall"}, 32'(ALU_Stall_OUT),           32'(q.size() >= DEPTH - 1));
        chk({tag, ".data"},  write_register_data,          m_data);
        chk({tag, ".idx"},   32'(write_register_index),    32'(m_idx));
        chk({tag, ".rob"},   32'(Complete_ROBPointer_OUT), 32'(m_rob));
    endtask

    initial begin
        idle();
        alu(0, 0, 0, 0); mem(0, 0, 0, 0);
        idle();
        RESET = 1'b1; FREEZE = 1'b1;
        step("reset0");
        step("reset1");
        idle();

        // single ALU result bypasses straight to the outputs
        alu(5, 12, 1, 32'hDEADBEEF);
        step("bypass");
        chk("bypass.data_k", write_register_data, 32'hDEADBEEF);
        chk("bypass.idx_k", 32'(write_register_index), 32'd12);
        chk("bypass.rob_k", 32'(Complete_ROBPointer_OUT), 32'd5);
        idle();
        step("idle0");

        // MEM wins over ALU, ALU follows next cycle
        mem(1, 3, 1, 32'h1111_0001); alu(2, 4, 1, 32'h2222_0002);
        step("mem_alu0");
        chk("mem_alu0.rob_k", 32'(Complete_ROBPointer_OUT), 32'd1);
        idle();
        step("mem_alu1");
        chk("mem_alu1.rob_k", 32'(Complete_ROBPointer_OUT), 32'd2);
        step("mem_alu2");
        chk("mem_alu2.cv_k", 32'(Complete_Valid_OUT), 32'd0);

        // ALU result that completes without writing a register
        alu(7, 9, 0, 32'h0BAD_F00D);
        step("nowrite");
        chk("nowrite.cv_k", 32'(Complete_Valid_OUT), 32'd1);
        chk("nowrite.flag_k", 32'(write_register_flag), 32'd0);
        idle();

        // saturate the buffer while MEM holds the port
        for (int i = 0; i < 5; i++) begin
            mem(40 + i, i, 1, 32'hA000_0000 + i);
            alu(10 + i, 20 + i, 1, 32'hB000_0000 + i);
            step("ovf_fill");
        end
        chk("ovf.flag_k", 32'(Overflow_OUT), 32'd1);
        idle();
        for (int i = 0; i < 5; i++) begin
            step("ovf_drain");
            if (i < 4) chk("ovf_drain.rob_k", 32'(Complete_ROBPointer_OUT), 32'(10 + i));
        end
        RESET = 1'b1;
        step("ovf_clear");
        idle();

        // freeze holds two buffered entries
        mem(1, 1, 1, 32'h1); alu(2, 2, 1, 32'h2);
        step("frz_a");
        mem(3, 3, 1, 32'h3); alu(4, 4, 1, 32'h4);
        step("frz_b");
        FREEZE = 1'b1;
        mem(50, 5, 1, 32'h55); alu(51, 6, 1, 32'h66);
        for (int i = 0; i < 3; i++) step("frz_hold");
        idle();
        step("frz_rel0");
        chk("frz_rel0.rob_k", 32'(Complete_ROBPointer_OUT), 32'd2);
        step("frz_rel1");
        chk("frz_rel1.rob_k", 32'(Complete_ROBPointer_OUT), 32'd4);
        step("frz_rel2");

        // reset with three entries buffered
        for (int i = 0; i < 3; i++) begin
            mem(30 + i, 1, 1, 32'hC0 + i); alu(20 + i, 2, 1, 32'hD0 + i);
            step("rst_fill");
        end
        RESET = 1'b1; FREEZE = 1'b1;
        mem(60, 1, 1, 32'hE0); alu(61, 2, 1, 32'hF0);
        step("rst_mid");
        chk("rst_mid.stall_k", 32'(ALU_Stall_OUT), 32'd0);
        chk("rst_mid.data_k", write_register_data, 32'd0);
        idle();
        for (int i = 0; i < 3; i++) step("rst_after");

        // random traffic, mostly honouring the stall
        for (int i = 0; i < 400; i++) begin
            bit ign;
            idle();
            RESET  = ($urandom_range(0, 59) == 0);
            FREEZE = ($urandom_range(0, 7) == 0);
            ign    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0)
                mem($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1), $urandom);
            if ($urandom_range(0, 1) == 1 && (ign || q.size() < DEPTH - 1))
                alu($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1), $urandom);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter ROBINDEX, default 6, ROB pointer width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, ALU result buffer entries (power of two, >=4).
REQ-003 SHALL have CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have FREEZE  input  1  pipeline hold.
REQ-006 SHALL have ALU_Valid_IN  input  1  ALU result present this cycle.
REQ-007 SHALL have ALU_ROBPointer_IN  input  ROBINDEX  ROB entry of ALU result.
REQ-008 SHALL have ALU_Dest_IN  input  6  physical destination of ALU result.
REQ-009 SHALL have ALU_RegWrite_IN  input  1  ALU result writes a register.
REQ-010 SHALL have ALU_Data_IN  input  32  ALU result value.
REQ-011 SHALL have MEM_Valid_IN, MEM_ROBPointer_IN, MEM_Dest_IN, MEM_RegWrite_IN, MEM_Data_IN  input  1/ROBINDEX/6/1/32  memory-pipe equivalents of REQ-006..010.
REQ-012 SHALL have write_register_data  output  32  register-file write data.
REQ-013 SHALL have write_register_index  output  6  register-file write index.
REQ-014 SHALL have write_register_flag  output  1  register-file write enable.
REQ-015 SHALL have Complete_Valid_OUT  output  1  ROB completion strobe.
REQ-016 SHALL have Complete_ROBPointer_OUT  output  ROBINDEX  ROB entry completed.
REQ-017 SHALL have ALU_Stall_OUT  output  1  ALU pipe must not present new results.
REQ-018 SHALL have Overflow_OUT  output  1  sticky error: ALU result dropped.

Function
REQ-019 SHALL retire at most one result per non-frozen cycle, selected by fixed priority: MEM input > FIFO head > ALU input (bypass).
REQ-020 SHALL register all outputs except ALU_Stall_OUT; a selected result appears on outputs exactly one cycle after its input/selection edge.
REQ-021 SHALL drive Complete_Valid_OUT=1 for every selected result; write_register_flag = selected result's RegWrite; data/index/ROB pointer from selected result.
REQ-022 SHALL push a valid ALU input into the FIFO tail when it is not selected (MEM valid or FIFO non-empty).
REQ-023 SHALL bypass the ALU input straight to outputs only when FIFO empty and MEM_Valid_IN=0.
REQ-024 SHALL preserve ALU result order: FIFO head always retires before a younger ALU input.
REQ-025 SHALL allow simultaneous push and pop in one cycle; count unchanged.
REQ-026 SHALL drive ALU_Stall_OUT combinationally = (count >= FIFO_DEPTH-1).
REQ-027 SHALL, on ALU push while count==FIFO_DEPTH with no pop, drop the ALU result and set Overflow_OUT=1 until reset.
REQ-028 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-029 SHALL, while FREEZE=1, hold FIFO contents, pointers, count and Overflow_OUT, ignore all inputs, and drive write_register_flag=0 and Complete_Valid_OUT=0 on the next edge.
REQ-030 SHALL, when no result is selected, drive write_register_flag=0 and Complete_Valid_OUT=0; data/index/pointer outputs hold last value.

Reset
REQ-031 SHALL, with RESET=1 at a rising edge, clear count and pointers to 0, all outputs to 0, Overflow_OUT to 0; RESET overrides FREEZE and in-flight inputs.
REQ-032 SHALL discard FIFO contents on reset mid-operation; no stale result retires afterward.

Verification
REQ-033 SHALL pass: ALU only, ROB=5, dest=12, data=0xDEADBEEF, RegWrite=1 -> next cycle flag=1, index=12, data=0xDEADBEEF, Complete ROB=5.
REQ-034 SHALL pass: MEM (ROB=1) and ALU (ROB=2) same cycle -> cycle+1 retires ROB=1, cycle+2 retires ROB=2, count returns to 0.
REQ-035 SHALL pass: MEM valid 5 consecutive cycles with ALU valid each cycle, ALU ignoring stall -> ALU_Stall_OUT=1 once count=3, 5th ALU result dropped, Overflow_OUT=1, 4 buffered ALU results retire in order after MEM stops.
REQ-036 SHALL pass: ALU result with RegWrite=0 (store/branch) -> Complete_Valid_OUT=1, write_register_flag=0.
REQ-037 SHALL pass: FIFO holding 2 entries, FREEZE=1 for 3 cycles -> no completions, count stays 2; after release entries retire on consecutive cycles.
REQ-038 SHALL pass: RESET=1 with count=3 -> next cycle count=0, all outputs 0, ALU_Stall_OUT=0, no further completions without new inputs.
